// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_ctrl_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );

endinterface

// File: rtl/full_adder_df.sv
// Dataflow 1-bit full adder; the shared bit-slice of the serial adder.
module full_adder_df (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder sequenced LSB-first over WIDTH cycles by a small FSM.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum, fa_carry;

  full_adder_df u_fa (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .c_i     (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          // carry_q here is the carry into the MSB
          cmsb_d  = carry_q;
          state_d = StDone;
          sum_d   = res_sh_d;
          cout_d  = fa_carry;
          ovf_d   = cmsb_d ^ fa_carry;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and checks the full busy/done timeline and result.
  // Returns in the done cycle so a following call starts back-to-back.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int restart_at);
    logic [W:0] exp_full;
    int         s;
    logic       exp_ovf;
    exp_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s        = int'($signed(a)) + int'($signed(b)) + (c ? 1 : 0);
    exp_ovf  = (s > 127) || (s < -128);

    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= int'(W); k++) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.cin = 1'($urandom);
      bus.start = (k == restart_at);
      check_eq("busy_run", 32'(bus.busy), 32'd1);
      check_eq("done_early", 32'(bus.done), 32'd0);
      step();
    end
    bus.start = 1'b0;
    check_eq("done_pulse", 32'(bus.done), 32'd1);
    check_eq("busy_in_done", 32'(bus.busy), 32'd0);
    check_eq("sum", 32'(bus.sum), 32'(exp_full[W-1:0]));
    check_eq("cout", 32'(bus.cout), 32'(exp_full[W]));
    check_eq("overflow", 32'(bus.overflow), 32'(exp_ovf));
  endtask

  initial begin
    logic [W-1:0] held;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = '1;
    bus.b     = '1;
    bus.cin   = 1'b1;
    step();
    step();
    bus.start = 1'b0;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_sum", 32'(bus.sum), 32'd0);
    check_eq("rst_cout", 32'(bus.cout), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    step();

    run_op(8'h0F, 8'h01, 1'b0, 0);
    step();
    check_eq("done_once", 32'(bus.done), 32'd0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    step();

    // start during RUN is ignored
    run_op(8'h5A, 8'h33, 1'b1, 3);
    step();
    check_eq("no_queued_op", 32'(bus.busy), 32'd0);
    check_eq("no_second_done", 32'(bus.done), 32'd0);

    // back-to-back pair
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'h12, 8'h34, 1'b1, 0);
    step();

    // reset during RUN aborts
    bus.a = 8'h44; bus.b = 8'h55; bus.cin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k < 4; k++) step();
    rst_n = 1'b0;
    step();
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_sum", 32'(bus.sum), 32'd0);
    check_eq("abort_cout", 32'(bus.cout), 32'd0);
    check_eq("abort_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check_eq("abort_no_done", 32'(bus.done), 32'd0);
    end

    // random sweep, mixing back-to-back and idle gaps with held results
    for (int i = 0; i < 300; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 5 : 0);
      if ($urandom_range(0, 1) == 1) begin
        held = bus.sum;
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          step();
          check_eq("idle_done", 32'(bus.done), 32'd0);
          check_eq("sum_held", 32'(bus.sum), 32'(held));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
